// File: rtl/tmnt_snd_pkg.sv
// Shared types and clock constants for the Z80 sound command path.
package tmnt_snd_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE   = 2'd0,
        IRQ_ASSERT = 2'd1,
        IRQ_ACK    = 2'd2
    } irq_state_t;

    // Default clock rates; the 640 kHz YM/NEC enables will reuse MAIN_HZ.
    localparam int Z80_HZ  = 3579545;
    localparam int MAIN_HZ = 24000000;

endpackage

// File: rtl/tmnt_sound_cmd_frac_cen.sv
// Fractional NUM/DEN clock-enable generator: on average NUM pulses per DEN clocks.
module frac_cen #(
    parameter int NUM   = 3579545,
    parameter int DEN   = 24000000,
    parameter int ACC_W = 25
) (
    input  logic clk,
    input  logic rst_n,
    output logic cen
);

    localparam logic [ACC_W-1:0] NUM_W = ACC_W'(NUM);
    localparam logic [ACC_W-1:0] DEN_W = ACC_W'(DEN);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_n;
    logic             hit;

    // ACC_W is sized so acc + NUM never wraps.
    always_comb begin
        acc_n = acc + NUM_W;
        hit   = (acc_n >= DEN_W);
    end

    // Phase accumulator; the pulse is registered so it is one clock wide and glitch-free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            cen <= 1'b0;
        end else begin
            cen <= hit;
            acc <= hit ? (acc_n - DEN_W) : acc_n;
        end
    end

endmodule

// File: rtl/tmnt_sound_cmd.sv
// Z80-side end of the 68k -> sound command path: sound latch, SNDON IRQ, Z80 clock enable.
//
// IRQ FSM
//   state      | meaning
//   IRQ_IDLE   | no request; waiting for a SNDON rising edge
//   IRQ_ASSERT | /INT low until the Z80 runs an interrupt-acknowledge cycle
//   IRQ_ACK    | /INT released; waiting for /M1 to end, rearm if SNDON rose meanwhile
module tmnt_sound_cmd
    import tmnt_snd_pkg::*;
#(
    parameter int CEN_NUM = Z80_HZ,
    parameter int CEN_DEN = MAIN_HZ,
    parameter int ACC_W   = 25
) (
    input  logic       clk_main,
    input  logic       nRESET,
    input  logic       SNDDT,
    input  logic       SNDON,
    input  logic [7:0] DB_IN,
    output logic       z80_cen,
    input  logic       z80_nM1,
    input  logic       z80_nIORQ,
    input  logic       z80_nLCS,
    output logic       z80_nINT,
    output logic [7:0] latch_dout,
    output logic       cmd_pending,
    output logic       cmd_overrun
);

    logic       snddt_q;
    logic       sndon_q;
    logic       lcs_q;
    logic       hist_valid;
    logic       wr_fall;
    logic       rd_rise;
    logic       sndon_rise;
    irq_state_t state;
    irq_state_t state_n;
    logic       rearm;
    logic       rearm_n;

    frac_cen #(
        .NUM   (CEN_NUM),
        .DEN   (CEN_DEN),
        .ACC_W (ACC_W)
    ) u_z80_cen (
        .clk   (clk_main),
        .rst_n (nRESET),
        .cen   (z80_cen)
    );

    // Edge decode. hist_valid suppresses a SNDON "edge" on the first clock after
    // reset, so a level held high through reset release never raises an IRQ.
    always_comb begin
        wr_fall    = snddt_q & ~SNDDT;
        rd_rise    = ~lcs_q & z80_nLCS;
        sndon_rise = hist_valid & ~sndon_q & SNDON;
    end

    // Strobe history registers, reset to the idle level of each strobe.
    always_ff @(posedge clk_main) begin
        if (!nRESET) begin
            snddt_q    <= 1'b1;
            sndon_q    <= 1'b0;
            lcs_q      <= 1'b1;
            hist_valid <= 1'b0;
        end else begin
            snddt_q    <= SNDDT;
            sndon_q    <= SNDON;
            lcs_q      <= z80_nLCS;
            hist_valid <= 1'b1;
        end
    end

    // Sound latch and status flags: a read clear on the same clock as a write
    // is applied first, so the new byte is pending without an overrun.
    always_ff @(posedge clk_main) begin
        if (!nRESET) begin
            latch_dout  <= 8'h00;
            cmd_pending <= 1'b0;
            cmd_overrun <= 1'b0;
        end else begin
            if (wr_fall) begin
                latch_dout  <= DB_IN;
                cmd_pending <= 1'b1;
                cmd_overrun <= (cmd_pending & ~rd_rise) | (cmd_overrun & ~rd_rise);
            end else if (rd_rise) begin
                cmd_pending <= 1'b0;
                cmd_overrun <= 1'b0;
            end
        end
    end

    // IRQ FSM next-state logic.
    always_comb begin
        state_n = state;
        rearm_n = rearm;
        unique case (state)
            IRQ_IDLE: begin
                if (sndon_rise) state_n = IRQ_ASSERT;
            end
            IRQ_ASSERT: begin
                if (!z80_nM1 && !z80_nIORQ) state_n = IRQ_ACK;
            end
            IRQ_ACK: begin
                if (z80_nM1) begin
                    state_n = (rearm || sndon_rise) ? IRQ_ASSERT : IRQ_IDLE;
                    rearm_n = 1'b0;
                end else if (sndon_rise) begin
                    rearm_n = 1'b1;
                end
            end
            default: begin
                state_n = IRQ_IDLE;
                rearm_n = 1'b0;
            end
        endcase
    end

    // IRQ FSM state register; /INT is registered from the next state.
    always_ff @(posedge clk_main) begin
        if (!nRESET) begin
            state    <= IRQ_IDLE;
            rearm    <= 1'b0;
            z80_nINT <= 1'b1;
        end else begin
            state    <= state_n;
            rearm    <= rearm_n;
            z80_nINT <= (state_n != IRQ_ASSERT);
        end
    end

endmodule

// File: doc/tmnt_sound_cmd.md
Name: tmnt_sound_cmd

Overview:
Z80-side end of the 68k→sound command path.
- Captures the command byte that the 68k writes on the SNDDT strobe into a sound latch.
- Converts the rising edge of the SNDON control bit into a Z80 /INT that is held until the Z80 acknowledges it.
- Serves latch reads to the Z80.
- Generates the 3.58 MHz Z80 clock enable from clk_main.
It sits between the 68k I/O decode (U45 outputs, IOWR register) and the future Z80 sound subsystem.

Parameters:
CEN_NUM, 3579545, numerator of the fractional Z80 clock-enable divider (target Hz)
CEN_DEN, 24000000, denominator (clk_main Hz)
ACC_W, 25, accumulator width; must hold CEN_DEN+CEN_NUM-1

Ports:
clk_main  in  1  24 MHz main clock; all logic is on its rising edge
nRESET  in  1  synchronous reset, active-low
SNDDT  in  1  active-low 68k sound-code write strobe, held low for the whole bus cycle
SNDON  in  1  level from IOWR register bit 3 (Z80 IRQ trigger)
DB_IN  in  8  68k write data, low byte
z80_cen  out  1  one-clk_main-wide Z80 clock-enable pulse
z80_nM1  in  1  Z80 /M1
z80_nIORQ  in  1  Z80 /IORQ
z80_nLCS  in  1  decoded active-low Z80 latch-read strobe (memory read at the latch address)
z80_nINT  out  1  active-low Z80 interrupt request
latch_dout  out  8  sound latch contents to the Z80 data bus
cmd_pending  out  1  latch written and not yet read by the Z80
cmd_overrun  out  1  sticky; latch was overwritten while pending

Behaviour:
- Reset (nRESET=0 at a clock edge) clears, or drives to its idle value, every register on that edge:
  - latch_dout=0x00, cmd_pending=0, cmd_overrun=0, z80_nINT=1, z80_cen=0, accumulator=0, IRQ FSM=IDLE.
  - Edge-detect history registers are set to their idle levels: SNDDT=1, SNDON=0, z80_nLCS=1.
- Reset mid-operation aborts any pending IRQ or command. SNDON held high across reset release must not fire an IRQ; an edge is required.
- Clock enable:
  - Each clock computes acc_n = acc + CEN_NUM.
  - If acc_n >= CEN_DEN: z80_cen=1 for that cycle and acc <= acc_n - CEN_DEN.
  - Otherwise: z80_cen=0 and acc <= acc_n.
  - Exactly floor(N*CEN_NUM/CEN_DEN) pulses occur in N clocks from reset; two pulses are never adjacent while CEN_NUM < CEN_DEN/2.
- Command write:
  - A falling edge of SNDDT (prev=1, now=0) loads DB_IN into latch_dout on that clock edge, so latch_dout shows the new byte the cycle after the edge is sampled.
  - Only one capture per strobe, regardless of strobe length.
  - If cmd_pending=1 at the capture, cmd_overrun is set. cmd_pending is then set.
- Latch read:
  - latch_dout is stable while z80_nLCS is low.
  - A rising edge of z80_nLCS (end of read) clears cmd_pending and cmd_overrun.
  - If a rising edge of z80_nLCS and a falling edge of SNDDT land on the same clock: the read clear applies first, then the write. Result: new byte latched, cmd_pending=1, cmd_overrun=0.
- IRQ FSM, states IDLE, ASSERT, ACK:
  - IDLE: z80_nINT=1. A rising edge of SNDON moves to ASSERT.
  - ASSERT: z80_nINT=0. The first clock with z80_nM1=0 and z80_nIORQ=0 moves to ACK. Further SNDON edges in this state are absorbed; no queueing.
  - ACK: z80_nINT=1. When z80_nM1 returns to 1: if a SNDON rising edge occurred during ACK (rearm flag), go to ASSERT; otherwise go to IDLE. The rearm flag clears on leaving ACK.
  - The FSM is independent of z80_cen; all strobes are sampled every clk_main.
- Internal width rules: 8-bit latch, ACC_W-bit unsigned accumulator, no overflow permitted by the ACC_W constraint.

Decomposition:
- Package tmnt_snd_pkg holds:
  - the IRQ state enum (IDLE/ASSERT/ACK, 2-bit);
  - default constants Z80_HZ=3579545 and MAIN_HZ=24000000 (reused later for the YM/NEC clock enables at 640 kHz).
- One sub-module, frac_cen: a parameterized NUM/DEN fractional clock-enable generator. The 640 kHz sound enables will reuse it.

Test Plan:
- Release reset, count z80_cen over 24000 clocks -> first pulse on the 7th clock after release; total 3579 pulses; no adjacent pulses.
- SNDDT low for 10 clocks with DB_IN=0x5A -> latch_dout=0x5A, cmd_pending=1, single capture; then z80_nLCS low 4 clocks and high -> cmd_pending=0, latch_dout stays 0x5A.
- Write 0x11 then 0x22 without a read -> latch_dout=0x22, cmd_overrun=1; Z80 read -> both flags 0. Same-clock nLCS rise and SNDDT fall with 0x33 -> latch 0x33, pending=1, overrun=0.
- SNDON 0→1 -> z80_nINT=0 next cycle; second SNDON pulse while asserted -> no effect; nM1=nIORQ=0 -> z80_nINT=1; nM1 high -> IDLE.
- SNDON pulse during ACK -> after nM1 rises, z80_nINT=0 again without a new edge; single ack then returns to IDLE.
- SNDON held high through nRESET low→high -> z80_nINT stays 1; nRESET asserted during ASSERT with pending=1 -> nINT=1, pending=0, latch 0x00 next cycle.
